// File: rtl/press_classifier.sv
// press_classifier
//   Turns a debounced button level into one of three gesture pulses:
//   short single press, long press, or double press. A single saturating
//   counter is reused by every state to time the press length (PRESS1)
//   and the inter-press gap (WAIT2).
//
// Parameters
//   LONG_CYC : consecutive pressed cycles that make a long press
//   DBL_CYC  : released cycles after a first press within which a second
//              press turns the gesture into a double press
//
// Ports
//   clk         in  : system clock, rising edge
//   reset_n     in  : asynchronous active-low reset
//   db          in  : debounced button level, 1 = pressed, synchronous to clk
//   short_tick  out : one-cycle pulse, short single press classified
//   long_tick   out : one-cycle pulse, long press classified
//   double_tick out : one-cycle pulse, double press classified
//   busy        out : high while a gesture is being tracked (state != IDLE)
module press_classifier #(
  parameter int LONG_CYC = 100_000_000,
  parameter int DBL_CYC  = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic db,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic busy
);

  localparam int MAX_CYC = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             short_tick_q, short_tick_d;
  logic             long_tick_q, long_tick_d;
  logic             double_tick_q, double_tick_d;

  // Saturating increment: the counter must never wrap back to a small value.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    short_tick_d  = 1'b0;
    long_tick_d   = 1'b0;
    double_tick_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (db) begin
          state_d = PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS1: begin
        // Release is tested first so that a release coinciding with the
        // long threshold is treated as a (short) release.
        if (!db) begin
          state_d = WAIT2;
          cnt_d   = CNT_ONE;
        end else if (cnt_inc == LONG_LIM) begin
          state_d     = LONG_HELD;
          cnt_d       = cnt_inc;
          long_tick_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (!db) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT2: begin
        // A new press coinciding with gap expiry still counts as a double.
        if (db) begin
          state_d = PRESS2;
        end else if (cnt_inc == DBL_LIM) begin
          state_d      = IDLE;
          cnt_d        = '0;
          short_tick_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESS2: begin
        if (!db) begin
          state_d       = IDLE;
          cnt_d         = '0;
          double_tick_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      short_tick_q  <= 1'b0;
      long_tick_q   <= 1'b0;
      double_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      short_tick_q  <= short_tick_d;
      long_tick_q   <= long_tick_d;
      double_tick_q <= double_tick_d;
    end
  end

  assign short_tick  = short_tick_q;
  assign long_tick   = long_tick_q;
  assign double_tick = double_tick_q;
  // busy stays high alongside long_tick because the button is still held.
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier
//   Randomized and directed stimulus for press_classifier, compared every
//   cycle against a gesture-level reference model, plus directed timing
//   and count checks for the short, long, double, boundary and reset cases.
module tb_press_classifier;

  localparam int LONG_CYC = 10;
  localparam int DBL_CYC  = 5;

  logic clk;
  logic reset_n;
  logic db;
  logic short_tick, long_tick, double_tick, busy;

  press_classifier #(
    .LONG_CYC(LONG_CYC),
    .DBL_CYC (DBL_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .db         (db),
    .short_tick (short_tick),
    .long_tick  (long_tick),
    .double_tick(double_tick),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: a gesture is a group of at most two presses. It
  // tracks whether a gesture is open, how many presses it has, whether the
  // button is currently held, and the length of the current run.
  bit m_active, m_held, m_long_done;
  int m_presses, m_run;
  bit e_short, e_long, e_dbl;

  task automatic model_reset();
    m_active = 0; m_held = 0; m_long_done = 0; m_presses = 0; m_run = 0;
    e_short = 0; e_long = 0; e_dbl = 0;
  endtask

  task automatic model_step(input bit d);
    e_short = 0; e_long = 0; e_dbl = 0;
    if (!m_active) begin
      if (d) begin
        m_active = 1; m_presses = 1; m_held = 1; m_long_done = 0; m_run = 1;
      end
    end else if (m_long_done) begin
      if (!d) m_active = 0;
    end else if (m_presses == 2) begin
      if (!d) begin e_dbl = 1; m_active = 0; end
    end else if (m_held) begin
      if (d) begin
        m_run++;
        if (m_run == LONG_CYC) begin e_long = 1; m_long_done = 1; end
      end else begin
        m_held = 0; m_run = 1;
      end
    end else begin
      if (d) begin
        m_presses = 2; m_held = 1;
      end else begin
        m_run++;
        if (m_run == DBL_CYC) begin e_short = 1; m_active = 0; end
      end
    end
  endtask

  // Observed tick bookkeeping for directed scenarios.
  int cyc = 0;
  int n_short, n_long, n_dbl;
  int short_cyc, long_cyc, dbl_cyc;

  task automatic clr_counts();
    n_short = 0; n_long = 0; n_dbl = 0;
    short_cyc = -1; long_cyc = -1; dbl_cyc = -1;
  endtask

  // Drive one db sample; outputs are checked 1 ns after the edge that
  // samples it. cyc is the index of the sample; the tick is visible in
  // cycle cyc+1.
  task automatic step(input bit d);
    db = d;
    @(posedge clk);
    cyc++;
    model_step(d);
    #1;
    check("short_tick", short_tick, e_short);
    check("long_tick", long_tick, e_long);
    check("double_tick", double_tick, e_dbl);
    check("busy", busy, m_active);
    if (short_tick)  begin n_short++; short_cyc = cyc + 1; end
    if (long_tick)   begin n_long++;  long_cyc  = cyc + 1; end
    if (double_tick) begin n_dbl++;   dbl_cyc   = cyc + 1; end
  endtask

  task automatic steps(input bit d, input int n);
    for (int i = 0; i < n; i++) step(d);
  endtask

  // Asynchronous reset pulse starting mid-cycle, one clock long.
  task automatic reset_pulse(input bit db_val);
    db = db_val;
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ticks", {short_tick, long_tick, double_tick}, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int z, f, s, lvl, len;
    reset_n = 1'b0;
    db = 1'b0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_ticks", {short_tick, long_tick, double_tick}, 0);
    reset_n = 1'b1;
    steps(0, 3);

    // Short press: 4 high, then release.
    clr_counts();
    steps(1, 4);
    z = cyc + 1;
    steps(0, 8);
    check("short_n", n_short, 1);
    check("short_lat", short_cyc - z, DBL_CYC);
    check("short_other", n_long + n_dbl, 0);

    // Long press: 30 high.
    clr_counts();
    s = cyc + 1;
    steps(1, 30);
    step(0);
    check("long_n", n_long, 1);
    check("long_lat", long_cyc - s, LONG_CYC);
    check("long_idle_after", busy, 0);
    steps(0, 8);
    check("long_other", n_short + n_dbl, 0);

    // Double press: 3 high, 2 low, 20 high, release.
    clr_counts();
    steps(1, 3);
    steps(0, 2);
    steps(1, 20);
    f = cyc + 1;
    steps(0, 8);
    check("dbl_n", n_dbl, 1);
    check("dbl_lat", dbl_cyc - f, 1);
    check("dbl_other", n_short + n_long, 0);

    // Boundary: 9 high is still a short press.
    clr_counts();
    steps(1, LONG_CYC - 1);
    steps(0, 8);
    check("b9_short", n_short, 1);
    check("b9_long", n_long, 0);

    // Boundary: gap of 4 gives a double press.
    clr_counts();
    steps(1, 2);
    steps(0, DBL_CYC - 1);
    steps(1, 2);
    steps(0, 8);
    check("gap4_dbl", n_dbl, 1);
    check("gap4_short", n_short, 0);

    // Boundary: gap of 5 gives a short press, then an independent one.
    clr_counts();
    steps(1, 2);
    steps(0, DBL_CYC);
    steps(1, 2);
    steps(0, 8);
    check("gap5_short", n_short, 2);
    check("gap5_dbl", n_dbl, 0);

    // Reset in WAIT2 with three released samples, then 20 quiet cycles.
    clr_counts();
    steps(1, 2);
    steps(0, 3);
    reset_pulse(0);
    steps(0, 20);
    check("rst_quiet", n_short + n_long + n_dbl, 0);

    // Reset released with the button already held is a new press.
    clr_counts();
    reset_pulse(1);
    step(1);
    check("rst_newpress", busy, 1);
    steps(0, 8);
    check("rst_newpress_short", n_short, 1);

    // Randomized runs of alternating levels with occasional resets.
    lvl = 0;
    for (int b = 0; b < 80; b++) begin
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 149) == 0) reset_pulse(lvl[0]);
        step(lvl[0]);
      end
      lvl = 1 - lvl;
    end
    steps(0, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
